// File: rtl/fetch_unit.sv
// fetch_unit: three-cycle instruction fetch stage (request, wait, hold) in front of a synchronous-read memory.
// Optional build macro FETCH_MISALIGN_TRAP_EN: misaligned redirect targets trap instead of being silently aligned.
module fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef FETCH_MISALIGN_TRAP_EN
  ,
  output logic              fetch_misaligned
`endif
);

`ifdef FETCH_MISALIGN_TRAP_EN
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_TRAP} state_t;
`else
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD} state_t;
`endif

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] aligned_pc;
  logic              redir_bad;

  assign aligned_pc = redirect_pc & ~ADDR_W'(3);

`ifdef FETCH_MISALIGN_TRAP_EN
  assign redir_bad = |redirect_pc[1:0];
`else
  assign redir_bad = 1'b0;
`endif

  assign mem_addr  = pc;
  assign mem_rstrb = (state == S_REQ);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_REQ;
    end else begin
      state <= state_next;
    end
  end

  // A redirect overrides whatever the sequencer was about to do.
  always_comb begin
    state_next = state;
    if (redirect) begin
`ifdef FETCH_MISALIGN_TRAP_EN
      state_next = redir_bad ? S_TRAP : S_REQ;
`else
      state_next = S_REQ;
`endif
    end else begin
      case (state)
        S_REQ:   state_next = S_WAIT;
        S_WAIT:  state_next = S_HOLD;
        S_HOLD:  if (instr_ready) state_next = S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
        S_TRAP:  state_next = S_TRAP;
`endif
        default: state_next = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pc          <= RESET_PC;
      instr       <= 32'h0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (redirect) begin
      pc          <= redir_bad ? redirect_pc : aligned_pc;
      instr_valid <= 1'b0;
    end else begin
      case (state)
        S_WAIT: begin
          instr       <= mem_rdata;
          instr_pc    <= pc;
          instr_valid <= 1'b1;
          pc          <= pc + ADDR_W'(4);
        end
        S_HOLD: begin
          if (instr_ready) instr_valid <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef FETCH_MISALIGN_TRAP_EN
  // Sticky until the next redirect; an aligned one clears it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fetch_misaligned <= 1'b0;
    end else if (redirect) begin
      fetch_misaligned <= redir_bad;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed and randomized bench for fetch_unit; a scoreboard checks every delivered word.
// The expected word stream is "consecutive words from the last reset/redirect target".
module tb_fetch_unit;

  localparam int          ADDR_W   = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rstrb;
  logic [31:0] mem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
`ifdef FETCH_MISALIGN_TRAP_EN
  logic        fetch_misaligned;
`endif

  typedef struct {
    bit          mark;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ahead_pc;
  logic [31:0] rpc;
  int          n_compared = 0;
  int          n_failed = 0;
  exp_t        mon_e;
  bit          mon_red;

  fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
    .clk         (clk),
    .resetn      (resetn),
    .mem_addr    (mem_addr),
    .mem_rstrb   (mem_rstrb),
    .mem_rdata   (mem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    .fetch_misaligned (fetch_misaligned)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    if (a == 32'h4) return 32'h0010_0093;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory returns data one cycle after the strobe; garbage otherwise so stray captures show up.
  always @(posedge clk) mem_rdata <= mem_rstrb ? mem_word(mem_addr) : $urandom;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic push_item(input bit mark, input logic [31:0] a);
    exp_t e;
    e.mark = mark;
    e.pc   = a;
    exp_q.push_back(e);
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      push_item(1'b0, ahead_pc);
      ahead_pc = ahead_pc + 32'd4;
    end
  endtask

  task automatic applyStimulus(input bit redir, input logic [31:0] target, input bit rdy);
    redirect    = redir;
    redirect_pc = target;
    instr_ready = rdy;
    if (redir) begin
      push_item(1'b1, target & ~32'h3);
      ahead_pc = target & ~32'h3;
      for (int i = 0; i < 4; i++) begin
        push_item(1'b0, ahead_pc);
        ahead_pc = ahead_pc + 32'd4;
      end
    end
    refill();
  endtask

  task automatic cycle();
    @(negedge clk);
    #1;
  endtask

  task automatic start_reset();
    resetn   = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    ahead_pc = RESET_PC;
    refill();
  endtask

  task automatic do_reset();
    start_reset();
    cycle();
    resetn = 1'b1;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!instr_valid && n < 20) begin
      cycle();
      n++;
    end
    if (!instr_valid) begin
      n_compared++;
      n_failed++;
      $display("[TB] FAIL %s_timeout: instr_valid=0, expected 1 within 20 cycles", tag);
    end
  endtask

  // Monitor: samples just before each posedge, pops on handshakes, flushes on redirects.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      mon_red = resetn && redirect;
      if (resetn && instr_valid && instr_ready) begin
        if (exp_q.size() == 0) begin
          checkOutput("sb_underflow", 32'h1, 32'h0);
        end else begin
          mon_e = exp_q.pop_front();
          checkOutput("sb_is_word", {31'h0, mon_e.mark}, 32'h0);
          checkOutput("sb_instr_pc", instr_pc, mon_e.pc);
          checkOutput("sb_instr", instr, mem_word(mon_e.pc));
        end
      end
      if (resetn && mem_rstrb) checkOutput("strobe_aligned", {30'h0, mem_addr[1:0]}, 32'h0);
      if (mon_red) begin
        while (exp_q.size() > 0) begin
          mon_e = exp_q.pop_front();
          if (mon_e.mark) break;
        end
      end
      @(posedge clk);
      #1;
      if (mon_red) checkOutput("valid_after_redirect", {31'h0, instr_valid}, 32'h0);
    end
  end

  initial begin
    $display("[TB] fetch_unit bench start");
    repeat (2) @(negedge clk);
    do_reset();
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("c1_rstrb", {31'h0, mem_rstrb}, 32'h1);
    checkOutput("c1_addr", mem_addr, 32'h0);
    checkOutput("c1_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("c1_instr_rst", instr, 32'h0);
    cycle();
    checkOutput("c2_rstrb", {31'h0, mem_rstrb}, 32'h0);
    checkOutput("c2_valid", {31'h0, instr_valid}, 32'h0);
    cycle();
    checkOutput("c3_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("c3_instr", instr, 32'h0000_0013);
    checkOutput("c3_pc", instr_pc, 32'h0);
    cycle();
    checkOutput("c4_rstrb", {31'h0, mem_rstrb}, 32'h1);
    checkOutput("c4_addr", mem_addr, 32'h4);
    checkOutput("c4_valid", {31'h0, instr_valid}, 32'h0);
    cycle();
    cycle();
    checkOutput("c6_valid", {31'h0, instr_valid}, 32'h1);
    checkOutput("c6_instr", instr, 32'h0010_0093);
    checkOutput("c6_pc", instr_pc, 32'h4);

    // Backpressure on the word from pc=8.
    cycle();
    cycle();
    cycle();
    checkOutput("bp_valid", {31'h0, instr_valid}, 32'h1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      checkOutput("bp_hold_valid", {31'h0, instr_valid}, 32'h1);
      checkOutput("bp_hold_pc", instr_pc, 32'h8);
      checkOutput("bp_hold_instr", instr, mem_word(32'h8));
      checkOutput("bp_no_strobe", {31'h0, mem_rstrb}, 32'h0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    cycle();
    checkOutput("bp_resume_rstrb", {31'h0, mem_rstrb}, 32'h1);
    checkOutput("bp_resume_addr", mem_addr, 32'hC);

    // Redirect while the read is in flight.
    cycle();
    applyStimulus(1'b1, 32'h40, 1'b1);
    cycle();
    checkOutput("rw_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rw_rstrb", {31'h0, mem_rstrb}, 32'h1);
    checkOutput("rw_addr", mem_addr, 32'h40);
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_valid("rw");
    checkOutput("rw_instr_pc", instr_pc, 32'h40);

    // Redirect to a misaligned target coinciding with the handshake.
    applyStimulus(1'b1, 32'h103, 1'b1);
    cycle();
    checkOutput("rh_valid", {31'h0, instr_valid}, 32'h0);
`ifdef FETCH_MISALIGN_TRAP_EN
    checkOutput("rh_trap_flag", {31'h0, fetch_misaligned}, 32'h1);
    checkOutput("rh_trap_rstrb", {31'h0, mem_rstrb}, 32'h0);
    checkOutput("rh_trap_pc", mem_addr, 32'h103);
    applyStimulus(1'b0, 32'h0, 1'b1);
    cycle();
    checkOutput("rh_trap_stay", {31'h0, mem_rstrb}, 32'h0);
    applyStimulus(1'b1, 32'h100, 1'b1);
    cycle();
    checkOutput("rh_trap_clear", {31'h0, fetch_misaligned}, 32'h0);
`endif
    checkOutput("rh_rstrb", {31'h0, mem_rstrb}, 32'h1);
    checkOutput("rh_addr", mem_addr, 32'h100);
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_valid("rh");
    checkOutput("rh_instr_pc", instr_pc, 32'h100);

    // PC wrap at the top of the address space.
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    cycle();
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_valid("wrap");
    checkOutput("wrap_instr_pc", instr_pc, 32'hFFFF_FFFC);
    cycle();
    checkOutput("wrap_rstrb", {31'h0, mem_rstrb}, 32'h1);
    checkOutput("wrap_addr", mem_addr, 32'h0);

    // Reset during the wait state, then during hold.
    cycle();
    start_reset();
    #1;
    checkOutput("rst_wait_valid", {31'h0, instr_valid}, 32'h0);
    cycle();
    checkOutput("rst_no_capture", {31'h0, instr_valid}, 32'h0);
    resetn = 1'b1;
    checkOutput("rst_restart_rstrb", {31'h0, mem_rstrb}, 32'h1);
    checkOutput("rst_restart_addr", mem_addr, RESET_PC);
    applyStimulus(1'b0, 32'h0, 1'b1);
    wait_valid("rst");
    checkOutput("rst_first_pc", instr_pc, RESET_PC);
    start_reset();
    #1;
    checkOutput("rst_hold_valid", {31'h0, instr_valid}, 32'h0);
    checkOutput("rst_hold_instr", instr, 32'h0);
    cycle();
    resetn = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Randomized traffic: backpressure, redirects, occasional resets.
    for (int c = 0; c < 3000; c++) begin
      cycle();
      if ($urandom_range(0, 299) == 0) do_reset();
      rpc = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
      rpc[1:0] = 2'b00;
`endif
      applyStimulus($urandom_range(0, 11) == 0, rpc, $urandom_range(0, 3) != 0);
    end
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (6) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction fetch stage that sits directly upstream of the word-addressed synchronous-read memory. It drives that memory's mem_addr/mem_rstrb and consumes mem_rdata one cycle later. It holds the fetched word and its PC in output registers and offers them to decode under a valid/ready handshake. Branch and jump redirects from execute retarget the PC at any time and discard any in-flight read.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset; must be word aligned.
ADDR_W, 32, width of the PC and mem_addr.

Ports:
clk  in  1  system clock, all state updates on posedge.
resetn  in  1  asynchronous, active-low reset.
mem_addr  out  ADDR_W  byte address to memory; equals the current pc register in every state.
mem_rstrb  out  1  read strobe; 1 only in S_REQ.
mem_rdata  in  32  read data; valid in the cycle after mem_rstrb was sampled.
redirect  in  1  1 = load redirect_pc this cycle; takes priority over everything else.
redirect_pc  in  ADDR_W  new PC.
instr  out  32  fetched instruction word (registered).
instr_pc  out  ADDR_W  address instr was fetched from (registered).
instr_valid  out  1  instr/instr_pc hold a word not yet accepted.
instr_ready  in  1  decode accepts when instr_valid & instr_ready.

Behaviour:
- Reset (resetn low, async): pc=RESET_PC, state=S_REQ, instr_valid=0, instr=32'h0, instr_pc=0. mem_rstrb=1 is asserted in the first cycle after release.
- States:
  - S_REQ: mem_rstrb=1, mem_addr=pc; next state S_WAIT.
  - S_WAIT: mem_rdata is valid. On the edge: instr<=mem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4 (mod 2^ADDR_W, wraps silently); next state S_HOLD.
  - S_HOLD: instr, instr_pc and instr_valid are held stable while instr_ready=0. When instr_ready=1, instr_valid<=0 and the next state is S_REQ.
- Throughput is 1 instruction per 3 cycles with ready tied high. Latency is 2 cycles from strobe to instr_valid.
- Redirect, checked first in every state:
  - pc<=redirect_pc with bits [1:0] forced to 0, instr_valid<=0, state<=S_REQ.
  - In S_REQ: the strobe still fires, but the result is never captured.
  - In S_WAIT: mem_rdata is discarded; instr and instr_pc are unchanged.
  - In S_HOLD with instr_ready=1 in the same cycle: the handshake counts as completed (decode took the word), and the next fetch is from redirect_pc.
- instr_valid never rises in the same cycle that redirect=1.
- Asserting resetn mid-fetch aborts immediately; any pending memory result is ignored.

Optional Feature:
Macro FETCH_MISALIGN_TRAP_EN.
- Defined:
  - A redirect with redirect_pc[1:0]!=0 sets the sticky output fetch_misaligned (1 bit, reset 0) and loads pc with the unmodified redirect_pc.
  - The state goes to S_TRAP: mem_rstrb=0, instr_valid=0.
  - The block leaves S_TRAP only on an aligned redirect, which clears fetch_misaligned and enters S_REQ.
  - A further misaligned redirect while in S_TRAP keeps the block in S_TRAP and updates pc.
- Undefined: the fetch_misaligned port is absent and the low bits are silently cleared.

Test Plan:
- Reset release, RESET_PC=0, mem word0=32'h00000013, word1=32'h00100093, instr_ready=1 -> mem_rstrb high cycles 1 and 4; instr=00000013/instr_pc=0 valid cycle 3; instr=00100093/instr_pc=4 valid cycle 6.
- Backpressure: instr_ready=0 for 5 cycles after the first valid -> instr/instr_pc/instr_valid held stable; no mem_rstrb pulses; fetch of pc=4 starts the cycle after ready=1.
- Redirect in S_WAIT to 32'h40 -> instr_valid stays 0; next strobe has mem_addr=32'h40; next instr_pc=32'h40.
- Redirect coincident with handshake in S_HOLD, redirect_pc=32'h103 -> handshake completes; next mem_addr=32'h100 (macro off) or fetch_misaligned=1, no strobe (macro on).
- PC wrap: RESET_PC=32'hFFFF_FFFC -> first instr_pc=FFFFFFFC, second fetch mem_addr=0.
- resetn pulsed low during S_WAIT -> instr_valid=0 immediately; restart from RESET_PC.
